// File: rtl/sdram_responder_if.sv
// SDRAM command, address and byte-mask pins between a controller (master) and the device model (slave).
interface sdram_responder_if;
    logic        SDRAM_CKE;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic [1:0]  SDRAM_BA;
    logic [12:0] SDRAM_A;
    logic        SDRAM_DQML;
    logic        SDRAM_DQMH;

    modport master (
        output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );
    modport slave (
        input SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input SDRAM_BA, SDRAM_A, SDRAM_DQML, SDRAM_DQMH
    );
endinterface

// File: rtl/sdram_responder.sv
// Cycle-accurate 4-bank SDRAM device model: decodes commands, enforces tRCD/tRP/tRC,
// serves burst-1 reads at CAS latency 2 or 3 from an internal word store, and latches the first protocol error.
module sdram_responder #(
    parameter int MEM_AW = 14,
    parameter int TRCD   = 2,
    parameter int TRP    = 2,
    parameter int TRC    = 6
) (
    input  logic              clk,
    input  logic              reset,
    sdram_responder_if.slave  bus,
    inout  wire  [15:0]       SDRAM_DQ,
    output logic [12:0]       mode_reg,
    output logic              mode_valid,
    output logic [15:0]       refresh_cnt,
    output logic              err,
    output logic [2:0]        err_code
);
    localparam int CW = 8;
    // Timers load T-1 so a command seeing a zero count is at least T edges after the load.
    localparam logic [CW-1:0] TRCD_LD = CW'((TRCD > 0) ? TRCD - 1 : 0);
    localparam logic [CW-1:0] TRP_LD  = CW'((TRP  > 0) ? TRP  - 1 : 0);
    localparam logic [CW-1:0] TRC_LD  = CW'((TRC  > 0) ? TRC  - 1 : 0);

    logic [3:0]        cmd;
    logic              cmd_en, cmd_act, cmd_rw, cmd_pre, cmd_ref, cmd_lmr;
    logic [1:0]        ba;
    logic [12:0]       a;
    logic              trc_busy, mode_ok, cl3;
    logic [2:0]        ec;
    logic              mem_we, rd_ins;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [15:0]       mem_q [2**MEM_AW];

    logic [3:0]        active_q, active_d;
    logic [12:0]       row_q [4];
    logic [12:0]       row_d [4];
    logic [CW-1:0]     bank_cnt_q [4];
    logic [CW-1:0]     bank_cnt_d [4];
    logic [CW-1:0]     trc_cnt_q, trc_cnt_d;
    logic [12:0]       mode_reg_q, mode_reg_d;
    logic              mode_valid_q, mode_valid_d;
    logic [15:0]       refresh_cnt_q, refresh_cnt_d;
    logic              err_q, err_d;
    logic [2:0]        err_code_q, err_code_d;

    logic              rd_vld_p0_q, rd_vld_p0_d, rd_vld_p1_q, rd_vld_p1_d, dq_vld_p2_q, dq_vld_p2_d;
    logic [15:0]       rd_data_p0_q, rd_data_p0_d, rd_data_p1_q, rd_data_p1_d, dq_data_p2_q, dq_data_p2_d;
    logic [1:0]        rd_msk_p1_q, rd_msk_p1_d, dq_msk_p2_q, dq_msk_p2_d;
    logic [1:0]        dq_oe;

    assign cmd     = {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE};
    assign cmd_en  = bus.SDRAM_CKE && !bus.SDRAM_nCS;
    assign cmd_act = cmd_en && (cmd[2:0] == 3'b011);
    assign cmd_rw  = cmd_en && (cmd[2:1] == 2'b10);
    assign cmd_pre = cmd_en && (cmd[2:0] == 3'b010);
    assign cmd_ref = cmd_en && (cmd[2:0] == 3'b001);
    assign cmd_lmr = cmd_en && (cmd[2:0] == 3'b000);
    assign ba      = bus.SDRAM_BA;
    assign a       = bus.SDRAM_A;

    assign trc_busy  = (trc_cnt_q != '0);
    assign mode_ok   = (a[2:0] == 3'b000) && ((a[6:4] == 3'd2) || (a[6:4] == 3'd3));
    assign cl3       = (mode_reg_q[6:4] == 3'd3);
    assign mem_addr  = MEM_AW'({ba, row_q[ba], a[8:0]});
    assign mem_rdata = mem_q[mem_addr];

    always_comb begin
        active_d      = active_q;
        row_d         = row_q;
        for (int b = 0; b < 4; b++) begin
            bank_cnt_d[b] = (bank_cnt_q[b] != '0) ? bank_cnt_q[b] - 1'b1 : '0;
        end
        trc_cnt_d     = trc_busy ? trc_cnt_q - 1'b1 : '0;
        mode_reg_d    = mode_reg_q;
        mode_valid_d  = mode_valid_q;
        refresh_cnt_d = refresh_cnt_q;
        err_d         = err_q;
        err_code_d    = err_code_q;
        ec            = 3'd0;
        mem_we        = 1'b0;
        rd_ins        = 1'b0;

        if (cmd_act) begin
            if (active_q[ba])                          ec = 3'd1;
            else if ((bank_cnt_q[ba] != '0) || trc_busy) ec = 3'd7;
            else begin
                active_d[ba]   = 1'b1;
                row_d[ba]      = a;
                bank_cnt_d[ba] = TRCD_LD;
            end
        end
        if (cmd_rw) begin
            if (!active_q[ba])              ec = 3'd2;
            else if (bank_cnt_q[ba] != '0)  ec = 3'd3;
            else if (!mode_valid_q)         ec = 3'd4;
            else if (trc_busy)              ec = 3'd7;
            else begin
                mem_we = !cmd[0];
                rd_ins = cmd[0];
                if (a[10]) begin
                    active_d[ba]   = 1'b0;
                    bank_cnt_d[ba] = TRP_LD;
                end
            end
        end
        if (cmd_pre) begin
            if (trc_busy) ec = 3'd7;
            else begin
                for (int b = 0; b < 4; b++) begin
                    if (a[10] || (ba == 2'(b))) begin
                        active_d[b]   = 1'b0;
                        bank_cnt_d[b] = TRP_LD;
                    end
                end
            end
        end
        if (cmd_ref) begin
            if (|active_q)    ec = 3'd5;
            else if (trc_busy) ec = 3'd7;
            else begin
                refresh_cnt_d = refresh_cnt_q + 16'd1;
                trc_cnt_d     = TRC_LD;
            end
        end
        // An illegal mode word is still captured, but only when nothing else discards the command.
        if (cmd_lmr) begin
            if (|active_q)     ec = 3'd5;
            else if (!mode_ok) ec = 3'd6;
            else if (trc_busy) ec = 3'd7;
            if (!(|active_q) && !trc_busy) begin
                mode_reg_d   = a;
                mode_valid_d = mode_ok;
            end
        end
        if ((ec != 3'd0) && !err_q) begin
            err_d      = 1'b1;
            err_code_d = ec;
        end
    end

    // Read pipeline: CL3 enters p0, CL2 enters p1 directly; DQM is captured on entry to p1.
    always_comb begin
        rd_vld_p0_d  = rd_ins && cl3;
        rd_data_p0_d = mem_rdata;
        rd_vld_p1_d  = rd_vld_p0_q || (rd_ins && !cl3);
        rd_data_p1_d = rd_vld_p0_q ? rd_data_p0_q : mem_rdata;
        rd_msk_p1_d  = {bus.SDRAM_DQMH, bus.SDRAM_DQML};
        dq_vld_p2_d  = rd_vld_p1_q;
        dq_data_p2_d = rd_data_p1_q;
        dq_msk_p2_d  = rd_msk_p1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q      <= '0;
            for (int b = 0; b < 4; b++) bank_cnt_q[b] <= '0;
            trc_cnt_q     <= '0;
            mode_reg_q    <= '0;
            mode_valid_q  <= 1'b0;
            refresh_cnt_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            rd_vld_p0_q   <= 1'b0;
            rd_vld_p1_q   <= 1'b0;
            dq_vld_p2_q   <= 1'b0;
        end else begin
            active_q      <= active_d;
            bank_cnt_q    <= bank_cnt_d;
            trc_cnt_q     <= trc_cnt_d;
            mode_reg_q    <= mode_reg_d;
            mode_valid_q  <= mode_valid_d;
            refresh_cnt_q <= refresh_cnt_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            rd_vld_p0_q   <= rd_vld_p0_d;
            rd_vld_p1_q   <= rd_vld_p1_d;
            dq_vld_p2_q   <= dq_vld_p2_d;
        end
    end

    // Row latches, read data and the word store are not reset; the array survives reset.
    always_ff @(posedge clk) begin
        row_q        <= row_d;
        rd_data_p0_q <= rd_data_p0_d;
        rd_data_p1_q <= rd_data_p1_d;
        rd_msk_p1_q  <= rd_msk_p1_d;
        dq_data_p2_q <= dq_data_p2_d;
        dq_msk_p2_q  <= dq_msk_p2_d;
        if (mem_we) begin
            if (!bus.SDRAM_DQML) mem_q[mem_addr][7:0]  <= SDRAM_DQ[7:0];
            if (!bus.SDRAM_DQMH) mem_q[mem_addr][15:8] <= SDRAM_DQ[15:8];
        end
    end

    assign dq_oe          = {2{dq_vld_p2_q}} & ~dq_msk_p2_q;
    assign SDRAM_DQ[7:0]  = dq_oe[0] ? dq_data_p2_q[7:0]  : 8'hzz;
    assign SDRAM_DQ[15:8] = dq_oe[1] ? dq_data_p2_q[15:8] : 8'hzz;

    assign mode_reg    = mode_reg_q;
    assign mode_valid  = mode_valid_q;
    assign refresh_cnt = refresh_cnt_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode load, writes with byte masks, CL2/CL3 reads, timing errors, refresh, reset.
module tb_sdram_responder;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tb_dq;
    logic        tb_dq_oe;
    wire  [15:0] dq;
    logic [12:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    sdram_responder_if bus ();
    assign dq = tb_dq_oe ? tb_dq : 16'hzzzz;

    sdram_responder #(.MEM_AW(14), .TRCD(2), .TRP(2), .TRC(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .SDRAM_DQ    (dq),
        .mode_reg    (mode_reg),
        .mode_valid  (mode_valid),
        .refresh_cnt (refresh_cnt),
        .err         (err),
        .err_code    (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One command per rising edge; returns 1ns after the edge that sampled it.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [1:0] dqm, input logic drv, input logic [15:0] d);
        @(negedge clk);
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = c;
        bus.SDRAM_BA = b;
        bus.SDRAM_A  = addr;
        {bus.SDRAM_DQMH, bus.SDRAM_DQML} = dqm;
        tb_dq    = d;
        tb_dq_oe = drv;
        @(posedge clk);
        #1;
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        {bus.SDRAM_DQMH, bus.SDRAM_DQML} = 2'b00;
        tb_dq_oe = 1'b0;
    endtask

    task automatic nop(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.SDRAM_CKE = 1'b1;
        {bus.SDRAM_nCS, bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE} = C_NOP;
        bus.SDRAM_BA = 2'd0;
        bus.SDRAM_A  = 13'd0;
        {bus.SDRAM_DQMH, bus.SDRAM_DQML} = 2'b00;
        tb_dq    = 16'h0000;
        tb_dq_oe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode_reg", 32'(mode_reg), 32'h0);
        chk("rst_mode_valid", 32'(mode_valid), 32'h0);
        chk("rst_refresh_cnt", 32'(refresh_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_code", 32'(err_code), 32'h0);
        chk("rst_dq_oe", 32'(dut.dq_oe), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // CL2 mode, write BEEF to bank0 row5 col3 with auto-precharge
        issue(C_LMR, 2'd0, 13'h0220, 2'b00, 1'b0, 16'h0);
        chk("lmr_mode_reg", 32'(mode_reg), 32'h0220);
        chk("lmr_mode_valid", 32'(mode_valid), 32'h1);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(2);
        issue(C_WR, 2'd0, 13'h0403, 2'b00, 1'b1, 16'hBEEF);
        chk("wr_err", 32'(err), 32'h0);
        nop(1);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        chk("reopen_after_autopre_err", 32'(err), 32'h0);
        nop(1);
        issue(C_RD, 2'd0, 13'h0403, 2'b00, 1'b0, 16'h0);
        chk("cl2_rd_n1_oe", 32'(dut.dq_oe), 32'h0);
        nop(1);
        chk("cl2_rd_n2_oe", 32'(dut.dq_oe), 32'h3);
        chk("cl2_rd_n2_dq", 32'(dq), 32'hBEEF);
        nop(1);
        chk("cl2_rd_n3_oe", 32'(dut.dq_oe), 32'h0);

        // Upper byte masked write over BEEF
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(1);
        issue(C_WR, 2'd0, 13'h0403, 2'b10, 1'b1, 16'h1234);
        nop(1);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(1);
        issue(C_RD, 2'd0, 13'h0403, 2'b00, 1'b0, 16'h0);
        nop(1);
        chk("mask_wr_oe", 32'(dut.dq_oe), 32'h3);
        chk("mask_wr_dq", 32'(dq), 32'hBE34);
        nop(1);

        // READ one cycle after ACTIVE violates tRCD
        issue(C_ACT, 2'd1, 13'd7, 2'b00, 1'b0, 16'h0);
        issue(C_RD, 2'd1, 13'h0000, 2'b00, 1'b0, 16'h0);
        chk("trcd_err", 32'(err), 32'h1);
        chk("trcd_err_code", 32'(err_code), 32'h3);
        for (int i = 0; i < 3; i++) begin
            chk("trcd_no_drive", 32'(dut.dq_oe), 32'h0);
            nop(1);
        end

        reset = 1'b1;
        #2;
        chk("async_rst_err", 32'(err), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Refresh spacing and refresh with an open bank
        issue(C_LMR, 2'd0, 13'h0220, 2'b00, 1'b0, 16'h0);
        issue(C_REF, 2'd0, 13'h0, 2'b00, 1'b0, 16'h0);
        nop(7);
        issue(C_REF, 2'd0, 13'h0, 2'b00, 1'b0, 16'h0);
        nop(7);
        issue(C_REF, 2'd0, 13'h0, 2'b00, 1'b0, 16'h0);
        chk("ref3_cnt", 32'(refresh_cnt), 32'd3);
        chk("ref3_err", 32'(err), 32'h0);
        nop(7);
        issue(C_ACT, 2'd2, 13'd9, 2'b00, 1'b0, 16'h0);
        nop(2);
        issue(C_REF, 2'd0, 13'h0, 2'b00, 1'b0, 16'h0);
        chk("ref_open_cnt", 32'(refresh_cnt), 32'd3);
        chk("ref_open_err", 32'(err), 32'h1);
        chk("ref_open_err_code", 32'(err_code), 32'h5);

        reset = 1'b1;
        #2;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // CL3 read, then reset while the data is on the bus
        issue(C_LMR, 2'd0, 13'h0030, 2'b00, 1'b0, 16'h0);
        chk("cl3_mode_valid", 32'(mode_valid), 32'h1);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(1);
        issue(C_RD, 2'd0, 13'h0003, 2'b00, 1'b0, 16'h0);
        nop(1);
        chk("cl3_rd_n2_oe", 32'(dut.dq_oe), 32'h0);
        nop(1);
        chk("cl3_rd_n3_oe", 32'(dut.dq_oe), 32'h3);
        chk("cl3_rd_n3_dq", 32'(dq), 32'hBE34);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_read_oe", 32'(dut.dq_oe), 32'h0);
        chk("rst_mid_read_mode_valid", 32'(mode_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_no_drive", 32'(dut.dq_oe), 32'h0);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(1);
        issue(C_RD, 2'd0, 13'h0003, 2'b00, 1'b0, 16'h0);
        chk("nomode_err", 32'(err), 32'h1);
        chk("nomode_err_code", 32'(err_code), 32'h4);

        // Illegal then legal mode, then data survives reset; low byte masked on read
        issue(C_PRE, 2'd0, 13'h0000, 2'b00, 1'b0, 16'h0);
        issue(C_LMR, 2'd0, 13'h0040, 2'b00, 1'b0, 16'h0);
        chk("bad_mode_reg", 32'(mode_reg), 32'h0040);
        chk("bad_mode_valid", 32'(mode_valid), 32'h0);
        issue(C_LMR, 2'd0, 13'h0220, 2'b00, 1'b0, 16'h0);
        chk("relmr_mode_valid", 32'(mode_valid), 32'h1);
        issue(C_ACT, 2'd0, 13'd5, 2'b00, 1'b0, 16'h0);
        nop(1);
        issue(C_RD, 2'd0, 13'h0403, 2'b01, 1'b0, 16'h0);
        chk("dqm_rd_n1_oe", 32'(dut.dq_oe), 32'h0);
        nop(1);
        chk("dqm_rd_n2_oe", 32'(dut.dq_oe), 32'h2);
        chk("dqm_rd_n2_dq_hi", 32'(dq[15:8]), 32'hBE);
        nop(1);
        chk("dqm_rd_n3_oe", 32'(dut.dq_oe), 32'h0);
        chk("sticky_err_code", 32'(err_code), 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
